// File: rtl/checksum_seq_pkg.sv
// Shared constants, FSM state type and byte classification for the
// line-checksum sequencer.
package checksum_seq_pkg;

    localparam logic [7:0]  CHAR_LF = 8'h0A;
    localparam logic [7:0]  CHAR_CR = 8'h0D;
    localparam int unsigned COUNT_W = 16;
    localparam int unsigned PROD_W  = 32;

    typedef enum logic [1:0] {
        ST_STREAM,
        ST_MUL,
        ST_DONE
    } state_e;

    function automatic logic is_delim(input logic [7:0] b);
        return (b == CHAR_LF) || (b == CHAR_CR);
    endfunction

endpackage

// File: rtl/checksum_seq_if.sv
// Operand/result bundle between the sequencer and its shift-add multiplier.
interface checksum_seq_if;
    import checksum_seq_pkg::*;

    logic               start;
    logic [COUNT_W-1:0] a;
    logic [COUNT_W-1:0] b;
    logic               busy;
    logic               done;
    logic [PROD_W-1:0]  p;

    modport master (output start, a, b, input busy, done, p);
    modport slave  (input start, a, b, output busy, done, p);

endinterface

// File: rtl/checksum_seq_mul.sv
// Unsigned 16x16 shift-add multiplier, one partial product per cycle;
// done pulses for one cycle 16 edges after start is sampled.
module mul_shift_add
    import checksum_seq_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    checksum_seq_if.slave m
);

    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [3:0]         cnt_q,    cnt_d;
    logic [PROD_W-1:0]  acc_q,    acc_d;
    logic [PROD_W-1:0]  mcand_q,  mcand_d;
    logic [COUNT_W-1:0] mplier_q, mplier_d;

    always_comb begin
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (m.start) begin
            // Bit 0 is folded into the load so the whole product takes 16 edges.
            acc_d    = m.b[0] ? {{(PROD_W-COUNT_W){1'b0}}, m.a} : '0;
            mcand_d  = {{(PROD_W-COUNT_W){1'b0}}, m.a} << 1;
            mplier_d = m.b >> 1;
            cnt_d    = 4'd15;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign m.busy = busy_q;
    assign m.done = done_q;
    assign m.p    = acc_q;

endmodule

// File: rtl/checksum_seq.sv
// Streams text lines into an external letter-count engine, counts lines
// with a doubled / tripled letter, and multiplies the two counts at end of input.
module checksum_seq
    import checksum_seq_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [7:0]         data_i,
    input  logic               vld_i,
    output logic               rdy_o,
    input  logic               eof_i,
    output logic [7:0]         ck_data_o,
    output logic               ck_vld_o,
    output logic               ck_rst_o,
    input  logic               ck_rep2_i,
    input  logic               ck_rep3_i,
    output logic [COUNT_W-1:0] count2_o,
    output logic [COUNT_W-1:0] count3_o,
    output logic [PROD_W-1:0]  checksum_o,
    output logic               done_o
);

    state_e             state_q,    state_d;
    logic               nonempty_q, nonempty_d;
    logic [COUNT_W-1:0] count2_q,   count2_d;
    logic [COUNT_W-1:0] count3_q,   count3_d;
    logic [PROD_W-1:0]  checksum_q, checksum_d;
    logic               line_end;
    logic               mul_start;

    checksum_seq_if mul_bus ();

    mul_shift_add u_mul (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .m     (mul_bus.slave)
    );

    always_comb begin
        state_d    = state_q;
        nonempty_d = nonempty_q;
        count2_d   = count2_q;
        count3_d   = count3_q;
        checksum_d = checksum_q;
        rdy_o      = 1'b0;
        ck_vld_o   = 1'b0;
        done_o     = 1'b0;
        line_end   = 1'b0;
        mul_start  = 1'b0;

        case (state_q)
            ST_STREAM: begin
                rdy_o = 1'b1;
                if (vld_i) begin
                    if (is_delim(data_i)) begin
                        line_end = nonempty_q;
                    end else begin
                        ck_vld_o   = 1'b1;
                        nonempty_d = 1'b1;
                    end
                end else if (eof_i) begin
                    line_end  = nonempty_q;
                    mul_start = 1'b1;
                    state_d   = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mul_bus.done && !mul_bus.busy) begin
                    checksum_d = mul_bus.p;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: done_o = 1'b1;
            default: state_d = ST_STREAM;
        endcase

        if (line_end) begin
            nonempty_d = 1'b0;
            if (ck_rep2_i && (count2_q != '1)) count2_d = count2_q + 16'd1;
            if (ck_rep3_i && (count3_q != '1)) count3_d = count3_q + 16'd1;
        end

        if (rst_i) ck_vld_o = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_STREAM;
            nonempty_q <= 1'b0;
            count2_q   <= '0;
            count3_q   <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            nonempty_q <= nonempty_d;
            count2_q   <= count2_d;
            count3_q   <= count3_d;
            checksum_q <= checksum_d;
        end
    end

    // Operands are the post-flush counts so the final line is included.
    assign mul_bus.start = mul_start;
    assign mul_bus.a     = count2_d;
    assign mul_bus.b     = count3_d;

    assign ck_data_o  = data_i;
    assign ck_rst_o   = rst_i | line_end;
    assign count2_o   = count2_q;
    assign count3_o   = count3_q;
    assign checksum_o = (state_q == ST_DONE) ? checksum_q : '0;

endmodule

// File: doc/checksum_seq.md
CHECKSUM_SEQ -- requirements
Module: checksum_seq

Interface
REQ-001 The block SHALL have one clock, clk_i, and one reset, rst_i, which is synchronous and active-high.
REQ-002 Ports, clock and reset first:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- data_i  in  8  input byte stream (ASCII); 0x0A and 0x0D are line delimiters.
- vld_i  in  1  data_i valid.
- rdy_o  out  1  block accepts the byte; a byte transfers when vld_i & rdy_o.
- eof_i  in  1  end-of-input pulse.
- ck_data_o  out  8  byte to the letter-count engine.
- ck_vld_o  out  1  byte valid to the engine.
- ck_rst_o  out  1  synchronous clear of the engine.
- ck_rep2_i  in  1  engine flag: some letter seen exactly twice.
- ck_rep3_i  in  1  engine flag: some letter seen exactly thrice.
- count2_o  out  16  number of lines with rep2.
- count3_o  out  16  number of lines with rep3.
- checksum_o  out  32  count2 * count3.
- done_o  out  1  checksum_o valid.

Function
REQ-003 The FSM SHALL have three states: STREAM (rdy_o=1), MUL (rdy_o=0) and DONE (rdy_o=0, done_o=1).
REQ-004 In STREAM, a transferred non-delimiter byte SHALL drive ck_data_o=data_i and ck_vld_o=1 combinationally in the same cycle, and SHALL set the line_nonempty register.
REQ-005 In STREAM, a transferred delimiter with line_nonempty=1 SHALL do the following in that cycle:
- sample ck_rep2_i and ck_rep3_i;
- increment count2_o and/or count3_o on the next edge;
- assert ck_rst_o for one cycle;
- clear line_nonempty.
REQ-006 A delimiter with line_nonempty=0, such as the LF of CRLF or a blank line, SHALL assert neither ck_rst_o nor ck_vld_o, and SHALL leave the counts unchanged.
REQ-007 ck_vld_o SHALL never be 1 for delimiter bytes, and SHALL never be 1 outside STREAM.
REQ-008 count2_o and count3_o SHALL saturate at 0xFFFF; no wrap-around.
REQ-009 eof_i in STREAM with vld_i=0 SHALL cause the following:
- if line_nonempty=1, flush the pending line exactly as in REQ-005 in the same cycle;
- transition to MUL on the next edge.
REQ-010 If eof_i and vld_i are both high in the same cycle, the byte SHALL be processed and eof_i ignored, so the source holds eof_i.
REQ-011 MUL SHALL compute count2 * count3 as an unsigned 32-bit shift-add product over exactly 16 cycles.
REQ-012 After MUL, the block SHALL enter DONE, where checksum_o is stable and done_o=1.
REQ-013 DONE SHALL be exited only by rst_i.
REQ-014 checksum_o SHALL read 0 whenever done_o=0.
REQ-015 Counts SHALL freeze once MUL is entered, and vld_i and eof_i SHALL be ignored outside STREAM.

Reset
REQ-016 While rst_i=1, the block SHALL drive ck_rst_o=1.
REQ-017 On rst_i, state SHALL become STREAM with the following values:
- count2_o=0, count3_o=0;
- checksum_o=0, done_o=0;
- line_nonempty=0;
- ck_vld_o=0.
REQ-018 rst_i SHALL take priority over every event, including mid-MUL and a simultaneous delimiter or eof_i; a reset during MUL SHALL abort the multiply with no partial result.
REQ-019 rdy_o SHALL be 1 from the first cycle after rst_i deasserts.

Structure
REQ-020 A shared package SHALL hold the following:
- CHAR_LF=8'h0A and CHAR_CR=8'h0D;
- COUNT_W=16 and PROD_W=32;
- the FSM state enum.
REQ-021 The multiplier SHALL be a sub-module, mul_shift_add, with the following interface:
- start, a, b inputs;
- busy, done, p outputs;
- 16-cycle latency.
REQ-022 checksum_seq SHALL contain the FSM, line_nonempty, the saturating counters, and the engine-side wiring.

Verification
REQ-023 The bench SHALL couple checksum_seq with the letter-count engine and cover these directed scenarios:
- "abcdef\nbababc\nabbcde\nabcccd\naabcdd\nabcdee\nababab\n" then eof -> count2=4, count3=3, checksum=12, done_o within 17 cycles of eof.
- CRLF endings on the same data -> identical results, with exactly 7 ck_rst_o pulses besides reset.
- Last line without a trailing newline, then eof -> that line counted via the REQ-009 flush.
- vld_i held low for random gaps mid-line -> same counts as the gap-free run.
- rst_i asserted on cycle 8 of MUL -> counts=0, done_o=0, and rdy_o=1 on the next cycle.
- 65540 lines of "aabbb\n" -> count2=count3=0xFFFF and checksum=0xFFFE0001.
